data_mem_ctrl: RTL and testbench

Parametrised data-memory controller for the MEM stage of the 5-stage pipeline. Byte-addressed, little-endian storage with RV32 load/store sizing (byte/half/word, signed/unsigned loads) and a configurable access latency. While an access is in flight it raises `stall` so the hazard unit can freeze the pipeline. Misaligned accesses are detected, and can optionally be trapped.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/byte_lane_ram.sv | 33 +++
 rtl/data_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------+
// | mem_pkg: shared funct3 codes, controller states and size decode     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Stores only know sb/sh/sw, so the unsigned load codes mean word for them.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B:    return 3'd1;
      F3_H:    return 3'd2;
      F3_BU:   return is_store ? 3'd4 : 3'd1;
      F3_HU:   return is_store ? 3'd4 : 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_ram.sv
// +--------------------------------------------------------------------+
// | byte_lane_ram: DEPTH_BYTES x 8 storage, 4-byte wrapped window       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module byte_lane_ram #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  // Lane i always maps to byte addr+i; the AW-bit add provides the wrap.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rd_lane
    assign rdata[8*g +: 8] = mem[addr + AW'(g)];
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// +--------------------------------------------------------------------+
// | data_mem_ctrl: MEM-stage load/store controller with fixed latency   |
// | Optional macro MISALIGN_TRAP_EN traps misaligned accesses. Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic        nop,
  output logic [31:0] readData,
  output logic        stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          is_store_q, is_store_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic          request;
  logic          commit;
  logic [2:0]    size;
  logic          mis_now;
  logic [3:0]    we_mask;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   load_ext;
  logic          unused_addr;

  assign unused_addr = ^address[31:AW];
  assign request     = (memRead | memWrite) & ~nop;
  assign commit      = (state_q == ST_WAIT) && (cnt_q == '0);
  assign size        = size_bytes(f3_q, is_store_q);

`ifdef MISALIGN_TRAP_EN
  assign mis_now = ((size == 3'd2) && addr_q[0]) || ((size == 3'd4) && (addr_q[1:0] != 2'b00));
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    we_mask = 4'b1111;
    case (size)
      3'd1:    we_mask = 4'b0001;
      3'd2:    we_mask = 4'b0011;
      default: we_mask = 4'b1111;
    endcase
  end

  // A reset coinciding with the commit edge must not let the write through.
  assign ram_we = (commit && is_store_q && !mis_now && !rst) ? we_mask : 4'b0000;

  byte_lane_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (addr_q),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    load_ext = ram_rdata;
    case (f3_q)
      F3_B:    load_ext = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
      F3_BU:   load_ext = {24'h0, ram_rdata[7:0]};
      F3_H:    load_ext = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
      F3_HU:   load_ext = {16'h0, ram_rdata[15:0]};
      default: load_ext = ram_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    is_store_d = is_store_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          addr_d     = address[AW-1:0];
          wdata_d    = writeData;
          f3_d       = funct3;
          is_store_d = memWrite;
          cnt_d      = CW'(LATENCY - 1);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (!is_store_q) rdata_d = mis_now ? 32'h0 : load_ext;
          mis_d   = mis_now;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        mis_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      is_store_q <= 1'b0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
    end
  end

  assign readData = rdata_q;
  assign stall    = !rst && (((state_q == ST_IDLE) && request) || (state_q == ST_WAIT));

`ifdef MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;
  localparam int MAX_CYC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        nop = 1'b0;
  logic [31:0] readData;
  logic        stall;
  logic        misaligned;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .funct3(funct3), .nop(nop),
    .readData(readData), .stall(stall), .misaligned(misaligned)
  );

  // Drives one access from IDLE and returns what was seen in its DONE cycle.
  task automatic run_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            output int st_cyc, output logic [31:0] rd, output logic mis);
    int guard = 0;
    st_cyc = 0;
    @(negedge clk);
    memRead = !wr; memWrite = wr; funct3 = f3; address = a; writeData = wd; nop = 1'b0;
    if (!wr) sb_q.push_back(exp_rd);
    #1;
    while (stall === 1'b1 && guard < MAX_CYC) begin
      st_cyc++; guard++;
      @(negedge clk); #1;
    end
    if (guard >= MAX_CYC) begin
      checks++; failures++;
      $display("FAIL timeout addr=%h stall never dropped", a);
    end
    rd = readData; mis = misaligned;
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; memRead = 1'b1; funct3 = F3_W; address = 32'h10;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL reset_readData got=%h exp=0", readData); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", misaligned); end
    memRead = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word();
    int st; logic [31:0] rd, e; logic mi;
    run_access(1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, st, rd, mi);
    checks++; if (st !== LAT + 1) begin failures++; $display("FAIL sw_stall got=%0d exp=%0d", st, LAT + 1); end
    for (int k = 0; k < 2; k++) begin
      run_access(0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, st, rd, mi);
      e = sb_q.pop_front();
      checks++; if (st !== LAT + 1) begin failures++; $display("FAIL lw_stall got=%0d exp=%0d", st, LAT + 1); end
      checks++; if (rd !== e) begin failures++; $display("FAIL lw_10 got=%h exp=%h", rd, e); end
    end
  endtask

  task automatic test_byte_half();
    int st; logic [31:0] rd, e; logic mi;
    logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_HU, F3_H, F3_HU};
    logic [31:0] adr [5] = '{32'h21, 32'h21, 32'h20, 32'h60, 32'h60};
    logic [31:0] exv [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008000, 32'hFFFF8001, 32'h00008001};
    run_access(1, F3_B, 32'h21, 32'hAAAAAA80, 32'h0, st, rd, mi);
    run_access(1, F3_H, 32'h60, 32'h55558001, 32'h0, st, rd, mi);
    for (int k = 0; k < 5; k++) begin
      run_access(0, f3s[k], adr[k], 32'h0, exv[k], st, rd, mi);
      e = sb_q.pop_front();
      checks++; if (rd !== e) begin failures++; $display("FAIL ld_sized%0d got=%h exp=%h", k, rd, e); end
    end
    run_access(1, F3_BU, 32'h70, 32'hA5A5A5A5, 32'h0, st, rd, mi);
    run_access(0, F3_W, 32'h70, 32'h0, 32'hA5A5A5A5, st, rd, mi);
    e = sb_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL st_f3_other got=%h exp=%h", rd, e); end
  endtask

  task automatic test_wrap();
    int st; logic [31:0] rd, e; logic mi;
    logic [31:0] adr [4] = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};
    logic [31:0] exv [4] = '{32'h44, 32'h33, 32'h22, 32'h11};
    run_access(1, F3_W, 32'h3FE, 32'h11223344, 32'h0, st, rd, mi);
    for (int k = 0; k < 4; k++) begin
      run_access(0, F3_BU, adr[k], 32'h0, exv[k], st, rd, mi);
      e = sb_q.pop_front();
      checks++; if (rd !== e) begin failures++; $display("FAIL wrap_byte%0d got=%h exp=%h", k, rd, e); end
    end
    run_access(0, F3_W, 32'h3FE, 32'h0, 32'h11223344, st, rd, mi);
    e = sb_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL wrap_lw got=%h exp=%h", rd, e); end
  endtask

  task automatic test_misalign();
    int st; logic [31:0] rd, e; logic mi;
`ifdef MISALIGN_TRAP_EN
    logic exp_mis = 1'b1;
    logic [31:0] exp_h = 32'h0, exp_w = 32'h0;
`else
    logic exp_mis = 1'b0;
    logic [31:0] exp_h = 32'h00003400, exp_w = 32'h00000012;
`endif
    run_access(1, F3_H, 32'h31, 32'h00001234, 32'h0, st, rd, mi);
    checks++; if (mi !== exp_mis) begin failures++; $display("FAIL sh_mis got=%b exp=%b", mi, exp_mis); end
    checks++; if (st !== LAT + 1) begin failures++; $display("FAIL sh_mis_stall got=%0d exp=%0d", st, LAT + 1); end
    run_access(0, F3_HU, 32'h30, 32'h0, exp_h, st, rd, mi);
    e = sb_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL sh_mis_mem got=%h exp=%h", rd, e); end
    checks++; if (mi !== 1'b0) begin failures++; $display("FAIL aligned_mis got=%b exp=0", mi); end
    run_access(0, F3_W, 32'h32, 32'h0, exp_w, st, rd, mi);
    e = sb_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL lw_mis got=%h exp=%h", rd, e); end
    checks++; if (mi !== exp_mis) begin failures++; $display("FAIL lw_mis_flag got=%b exp=%b", mi, exp_mis); end
    @(negedge clk); #1;
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", misaligned); end
  endtask

  task automatic test_rst_mid();
    int st; logic [31:0] rd, e; logic mi;
    @(negedge clk);
    memWrite = 1'b1; funct3 = F3_W; address = 32'h40; writeData = 32'hCAFEBABE;
    repeat (LAT) @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
    @(negedge clk); memWrite = 1'b0; rst = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%b exp=0", stall); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL post_rst_rd got=%h exp=0", readData); end
    run_access(0, F3_W, 32'h40, 32'h0, 32'h0, st, rd, mi);
    e = sb_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL rst_mid_mem got=%h exp=%h", rd, e); end
  endtask

  task automatic test_nop_hold();
    int st; logic [31:0] rd, e; logic mi; int stall_seen = 0;
    @(negedge clk);
    nop = 1'b1; memWrite = 1'b1; funct3 = F3_W; address = 32'h50; writeData = 32'h12345678;
    repeat (4) begin #1; if (stall !== 1'b0) stall_seen++; @(negedge clk); end
    nop = 1'b0; memWrite = 1'b0;
    checks++; if (stall_seen !== 0) begin failures++; $display("FAIL nop_stall got=%0d exp=0", stall_seen); end
    run_access(0, F3_W, 32'h50, 32'h0, 32'h0, st, rd, mi);
    e = sb_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL nop_mem got=%h exp=%h", rd, e); end
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL one_access got=%b exp=0", stall); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_wrap();
    test_misalign();
    test_rst_mid();
    test_nop_hold();
    checks++;
    if (sb_q.size() !== 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
